// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF chain: FSM encoding and default
// sizing so that compare logic and counter instances agree.
package ro_puf_pkg;

  localparam int unsigned RO_GATE_CYCLES_DEF = 100000;
  localparam int unsigned RO_CNT_W_DEF       = 20;
  localparam int unsigned RO_SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } ro_state_e;

  // Width of a down-counter that must hold values 0..cycles-1.
  function automatic int unsigned ro_gate_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer for an asynchronous RO signal plus a previous-sample
// register; emits a one-cycle pulse on each synchronized rising edge.
module ro_sync_edge
  import ro_puf_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts synchronized rising edges of ro_in over a GATE_CYCLES clk window.
// Build option RO_FREQ_SAT_EN: saturate the edge counter instead of wrapping.
module ro_freq_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = RO_GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = RO_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned       GATE_W    = ro_gate_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  ro_state_e         state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rise;

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_i (ro_in),
    .rise_o  (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        gate_d     = GATE_LOAD;
        state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
`ifdef RO_FREQ_SAT_EN
            edge_cnt_d = CNT_MAX;
`else
            edge_cnt_d = '0;
`endif
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
        if (gate_q == '0) begin
          // Latch the result from the next-state value so the final window
          // cycle's edge is included and count is valid alongside done.
          count_d    = edge_cnt_d;
          overflow_d = ovf_d;
          state_d    = ST_DONE;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_ARM) || (state_q == ST_COUNT);
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a CNT_W=20 instance and a CNT_W=4 instance
// share clock, reset, start and a programmable ring-oscillator stimulus.
module tb_ro_freq_counter;

  localparam int unsigned GATE = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ro_in = 1'b0;
  logic        start = 1'b0;
  logic        busy_m, done_m, ovf_m;
  logic [19:0] count_m;
  logic        busy_s, done_s, ovf_s;
  logic [3:0]  count_s;

  int ro_period = 0;
  logic ro_level = 1'b0;
  int checks = 0;
  int errors = 0;

  ro_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(20), .SYNC_STAGES(2)) dut_m (
    .clk(clk), .reset(reset), .ro_in(ro_in), .start(start),
    .busy(busy_m), .done(done_m), .count(count_m), .overflow(ovf_m)
  );

  ro_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .reset(reset), .ro_in(ro_in), .start(start),
    .busy(busy_s), .done(done_s), .count(count_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  // RO stimulus, phase locked to clk; period 0 means held at ro_level.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ro_period == 0) begin
        ro_in = ro_level;
      end else begin
        ph = (ph + 1) % ro_period;
        ro_in = (ph < ro_period / 2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; return edges until done (start edge counts as 1)
  // and the number of sampled busy cycles. Bounded at 400 cycles.
  task automatic measure(input logic pulse_mid, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      start = pulse_mid && (lat == 11 || lat == 51);
      if (busy_m) busy_n++;
    end while (!done_m && lat < 400);
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          period;
    logic        level;
    int unsigned exp_m;
    logic        eo_m;
    int unsigned exp_s;
    logic        eo_s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, busy_n, bad;
    int done_at[3];
    int cyc, nd;

    vecs[0] = '{"p10",    10, 1'b0, 10, 1'b0, 10, 1'b0};
    vecs[1] = '{"stuck0",  0, 1'b0,  0, 1'b0,  0, 1'b0};
    vecs[2] = '{"stuck1",  0, 1'b1,  0, 1'b0,  0, 1'b0};
`ifdef RO_FREQ_SAT_EN
    vecs[3] = '{"p4",      4, 1'b0, 25, 1'b0, 15, 1'b1};
    vecs[4] = '{"p5",      5, 1'b0, 20, 1'b0, 15, 1'b1};
`else
    vecs[3] = '{"p4",      4, 1'b0, 25, 1'b0,  9, 1'b1};
    vecs[4] = '{"p5",      5, 1'b0, 20, 1'b0,  4, 1'b1};
`endif
    vecs[5] = '{"p20",    20, 1'b0,  5, 1'b0,  5, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy_m), 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_count", 32'(count_m), 0);
    check("rst_ovf", 32'(ovf_m), 0);

    foreach (vecs[i]) begin
      ro_period = vecs[i].period;
      ro_level = vecs[i].level;
      repeat (8) @(negedge clk);
      measure(1'b0, lat, busy_n);
      check({vecs[i].name, "_lat"}, 32'(lat), GATE + 2);
      check({vecs[i].name, "_busy"}, 32'(busy_n), GATE + 1);
      check({vecs[i].name, "_done_s"}, 32'(done_s), 1);
      check({vecs[i].name, "_cnt_m"}, 32'(count_m), vecs[i].exp_m);
      check({vecs[i].name, "_ovf_m"}, 32'(ovf_m), 32'(vecs[i].eo_m));
      check({vecs[i].name, "_cnt_s"}, 32'(count_s), vecs[i].exp_s);
      check({vecs[i].name, "_ovf_s"}, 32'(ovf_s), 32'(vecs[i].eo_s));
      repeat (3) @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 32'(done_m), 0);
      check({vecs[i].name, "_hold_m"}, 32'(count_m), vecs[i].exp_m);
      check({vecs[i].name, "_hold_s"}, 32'(count_s), vecs[i].exp_s);
    end

    // start pulses during COUNT are ignored and not queued
    ro_period = 10;
    repeat (8) @(negedge clk);
    measure(1'b1, lat, busy_n);
    check("mid_start_lat", 32'(lat), GATE + 2);
    check("mid_start_cnt", 32'(count_m), 10);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_m || done_m) bad++;
    end
    check("mid_start_no_retrigger", 32'(bad), 0);

    // reset in the middle of COUNT aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (lat < 41);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy_m), 0);
    check("abort_done", 32'(done_m), 0);
    check("abort_count", 32'(count_m), 0);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (done_m || busy_m) bad++;
    end
    check("abort_no_done", 32'(bad), 0);
    measure(1'b0, lat, busy_n);
    check("after_abort_lat", 32'(lat), GATE + 2);
    check("after_abort_cnt", 32'(count_m), 10);

    // start held high: back-to-back measurements
    repeat (5) @(negedge clk);
    start = 1'b1;
    cyc = 0;
    nd = 0;
    while (nd < 3 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (done_m) begin
        done_at[nd] = cyc;
        check("b2b_cnt", 32'(count_m), 10);
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_ndone", 32'(nd), 3);
    if (nd == 3) begin
      check("b2b_first", 32'(done_at[0]), GATE + 2);
      check("b2b_gap1", 32'(done_at[1] - done_at[0]), GATE + 3);
      check("b2b_gap2", 32'(done_at[2] - done_at[1]), GATE + 3);
    end
    repeat (5) @(negedge clk);
    check("b2b_idle", 32'(busy_m), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
